// File: rtl/hazard_unit.sv
// ID-stage hazard controller: selects the opcode fed to Control (or a bubble), gates the
// PC / IF/ID / downstream pipe enables, and keeps saturating hazard statistics.
module hazard_unit #(
  parameter int INIT_BUBBLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       op_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             dmem_ready_i,
  output logic [5:0]       op_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             pipe_en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FREEZE = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic [5:0] BUBBLE_OP = 6'b111111;
  // With no fill bubbles the first cycle after reset release is already RUN.
  localparam state_t RST_STATE = (INIT_BUBBLES == 0) ? ST_RUN : ST_INIT;
  localparam int     IW        = (INIT_BUBBLES > 1) ? $clog2(INIT_BUBBLES) : 1;

  state_t          state_q, state_next;
  logic [IW-1:0]   init_cnt_q;
  logic            init_done;
  logic            active;
  logic            load_use;
  logic            redirect;
  logic            stall_inc, flush_inc, freeze_inc;

  assign init_done = (32'(init_cnt_q) + 32'd1) >= 32'(INIT_BUBBLES);
  assign active    = (state_q == ST_RUN) || (state_q == ST_FREEZE);
  assign load_use  = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == rs_i) || (idex_rt_i == rt_i));
  assign redirect  = branch_taken_i || jump_i;

  // Only the highest-priority event in a cycle is counted.
  assign freeze_inc = active && !dmem_ready_i;
  assign stall_inc  = active && dmem_ready_i && load_use;
  assign flush_inc  = active && dmem_ready_i && !load_use && redirect;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == ST_INIT) begin
        if (!init_done) init_cnt_q <= init_cnt_q + 1'b1;
      end else begin
        init_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_next = ST_INIT;
    case (state_q)
      ST_INIT:             state_next = init_done ? ST_RUN : ST_INIT;
      ST_RUN, ST_FREEZE:   state_next = dmem_ready_i ? ST_RUN : ST_FREEZE;
      default:             state_next = ST_INIT;
    endcase
  end

  always_comb begin
    op_o         = BUBBLE_OP;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b1;
    pipe_en_o    = 1'b1;
    if (active) begin
      if (!dmem_ready_i) begin
        op_o         = op_i;
        ifid_flush_o = 1'b0;
        pipe_en_o    = 1'b0;
      end else if (load_use) begin
        op_o         = BUBBLE_OP;
        ifid_flush_o = 1'b0;
      end else begin
        op_o         = op_i;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = redirect;
      end
    end
  end

  assign state_o = state_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      freeze_cnt_o <= '0;
    end else begin
      if (stall_inc)  stall_cnt_o  <= sat_inc(stall_cnt_o);
      if (flush_inc)  flush_cnt_o  <= sat_inc(flush_cnt_o);
      if (freeze_inc) freeze_cnt_o <= sat_inc(freeze_cnt_o);
    end
  end

endmodule
